// File: rtl/iq_demod_fs4.sv
// ---------------------------------------------------------------------------
// iq_demod_fs4
//
// Quadrature down-converter with an fs/4 local oscillator. Each ADC strobe
// mixes the complex IF sample with the current LO phase and registers the
// complex baseband result. At fs/4 the LO only takes the values -1, 0 and +1,
// so the mixer reduces to a swap/negate multiplexer.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   ADC_rdy     one-cycle strobe, I_IF/Q_IF valid
//   I_IF, Q_IF  signed IF sample (DATA_W bits)
//   I_BB, Q_BB  signed registered baseband sample (DATA_W bits)
//   demod_rdy   one-cycle strobe, I_BB/Q_BB updated this cycle
//   cosine_out  current LO cosine, 2-bit signed (01=+1, 00=0, 11=-1)
//   sine_out    current LO sine, same encoding
//
// LO_DIR = 0 rotates the spectrum down by fs/4, LO_DIR = 1 rotates it up.
// ---------------------------------------------------------------------------
module iq_demod_fs4 #(
  parameter int DATA_W = 7,
  parameter bit LO_DIR = 1'b0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ADC_rdy,
  input  logic signed [DATA_W-1:0] I_IF,
  input  logic signed [DATA_W-1:0] Q_IF,
  output logic signed [DATA_W-1:0] I_BB,
  output logic signed [DATA_W-1:0] Q_BB,
  output logic                     demod_rdy,
  output logic [1:0]               cosine_out,
  output logic [1:0]               sine_out
);

  typedef enum logic [1:0] {
    PH0 = 2'd0,  // cos +1, sin  0
    PH1 = 2'd1,  // cos  0, sin +1
    PH2 = 2'd2,  // cos -1, sin  0
    PH3 = 2'd3   // cos  0, sin -1
  } lo_state_t;

  localparam logic [1:0] LO_POS  = 2'b01;
  localparam logic [1:0] LO_ZERO = 2'b00;
  localparam logic [1:0] LO_NEG  = 2'b11;

  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  lo_state_t state, state_nxt;

  logic signed [DATA_W-1:0] mix_i, mix_q;

  // Negation with saturation: the most negative code has no positive twin,
  // so it maps onto the positive full-scale value instead of wrapping.
  function automatic logic signed [DATA_W-1:0] sat_neg(
    input logic signed [DATA_W-1:0] x
  );
    if (x == S_MIN) return S_MAX;
    else            return -x;
  endfunction

  // -------------------------------------------------------------------------
  // LO sequencer: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= PH0;
    else         state <= state_nxt;
  end

  // LO sequencer: next-state logic, advances only on a sample strobe
  always_comb begin
    // NOTE: a default assignment first keeps every path covered, so no latch
    // is inferred for combinational outputs.
    state_nxt = state;
    if (ADC_rdy) begin
      unique case (state)
        PH0: state_nxt = PH1;
        PH1: state_nxt = PH2;
        PH2: state_nxt = PH3;
        PH3: state_nxt = PH0;
      endcase
    end
  end

  // LO sequencer: output decode straight from the state register
  always_comb begin
    cosine_out = LO_ZERO;
    sine_out   = LO_ZERO;
    unique case (state)
      PH0: cosine_out = LO_POS;
      PH1: sine_out   = LO_POS;
      PH2: cosine_out = LO_NEG;
      PH3: sine_out   = LO_NEG;
    endcase
  end

  // -------------------------------------------------------------------------
  // Mixer: with one LO component zero and the other +/-1, each output is a
  // plain or negated copy of one input.
  //   sin = +1 (down):  I = Q_IF,  Q = -I_IF
  //   sin = -1 (down):  I = -Q_IF, Q = I_IF
  // Rotating up flips the sign of the sin terms, i.e. swaps those two cases.
  // -------------------------------------------------------------------------
  always_comb begin
    mix_i = I_IF;
    mix_q = Q_IF;
    unique case (state)
      PH0: begin
        mix_i = I_IF;
        mix_q = Q_IF;
      end
      PH1: begin
        if (!LO_DIR) begin
          mix_i = Q_IF;
          mix_q = sat_neg(I_IF);
        end else begin
          mix_i = sat_neg(Q_IF);
          mix_q = I_IF;
        end
      end
      PH2: begin
        mix_i = sat_neg(I_IF);
        mix_q = sat_neg(Q_IF);
      end
      PH3: begin
        if (!LO_DIR) begin
          mix_i = sat_neg(Q_IF);
          mix_q = I_IF;
        end else begin
          mix_i = Q_IF;
          mix_q = sat_neg(I_IF);
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers: results load on the strobe edge and hold otherwise.
  // -------------------------------------------------------------------------
  // NOTE: only these few control/data registers take the reset; there is no
  // storage array here that would need to stay out of the reset tree.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      I_BB      <= '0;
      Q_BB      <= '0;
      demod_rdy <= 1'b0;
    end else begin
      demod_rdy <= ADC_rdy;
      if (ADC_rdy) begin
        I_BB <= mix_i;
        Q_BB <= mix_q;
      end
    end
  end

endmodule

// File: tb/tb_iq_demod_fs4.sv
// ---------------------------------------------------------------------------
// tb_iq_demod_fs4
//
// Directed bench for iq_demod_fs4. Two instances share the stimulus: one
// rotating down (LO_DIR = 0) and one rotating up (LO_DIR = 1). Inputs are
// driven and outputs sampled on the falling clock edge, away from the active
// rising edge. Expected values are hand-computed in the stimulus calls.
// ---------------------------------------------------------------------------
module tb_iq_demod_fs4;

  localparam int DATA_W = 7;

  logic                     clk;
  logic                     resetn;
  logic                     ADC_rdy;
  logic signed [DATA_W-1:0] I_IF, Q_IF;

  logic signed [DATA_W-1:0] dn_i, dn_q, up_i, up_q;
  logic                     dn_rdy, up_rdy;
  logic [1:0]               dn_cos, dn_sin, up_cos, up_sin;

  int n_checks = 0;
  int n_fail   = 0;

  iq_demod_fs4 #(.DATA_W(DATA_W), .LO_DIR(1'b0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ADC_rdy    (ADC_rdy),
    .I_IF       (I_IF),
    .Q_IF       (Q_IF),
    .I_BB       (dn_i),
    .Q_BB       (dn_q),
    .demod_rdy  (dn_rdy),
    .cosine_out (dn_cos),
    .sine_out   (dn_sin)
  );

  iq_demod_fs4 #(.DATA_W(DATA_W), .LO_DIR(1'b1)) dut_up (
    .clk        (clk),
    .resetn     (resetn),
    .ADC_rdy    (ADC_rdy),
    .I_IF       (I_IF),
    .Q_IF       (Q_IF),
    .I_BB       (up_i),
    .Q_BB       (up_q),
    .demod_rdy  (up_rdy),
    .cosine_out (up_cos),
    .sine_out   (up_sin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One sample strobe, then four idle clocks (one strobe every 5 clocks).
  // Expected outputs for both the down and up converters are supplied.
  task automatic strobe(input string tag,
                        input int i_in, input int q_in,
                        input int e_di, input int e_dq,
                        input int e_ui, input int e_uq);
    @(negedge clk);
    ADC_rdy = 1'b1;
    I_IF    = DATA_W'(i_in);
    Q_IF    = DATA_W'(q_in);
    @(negedge clk);
    ADC_rdy = 1'b0;
    check({tag, " dn_rdy"}, int'(dn_rdy), 1);
    check({tag, " dn_i"},   int'(dn_i),   e_di);
    check({tag, " dn_q"},   int'(dn_q),   e_dq);
    check({tag, " up_i"},   int'(up_i),   e_ui);
    check({tag, " up_q"},   int'(up_q),   e_uq);
    I_IF = '0;
    Q_IF = '0;
    @(negedge clk);
    check({tag, " rdy low"}, int'(dn_rdy), 0);
    check({tag, " hold i"},  int'(dn_i),   e_di);
    repeat (2) @(negedge clk);
  endtask

  // LO state as a signed cos/sin pair, checked on the down converter
  task automatic check_lo(input string tag, input int e_cos, input int e_sin);
    check({tag, " cos"}, int'(dn_cos), e_cos);
    check({tag, " sin"}, int'(dn_sin), e_sin);
  endtask

  int exp_cos [4] = '{1, 0, 3, 0};
  int exp_sin [4] = '{0, 1, 0, 3};
  int exp_bi  [4] = '{20, 0, -20, 0};
  int exp_bq  [4] = '{0, -20, 0, 20};

  initial begin
    resetn  = 1'b0;
    ADC_rdy = 1'b0;
    I_IF    = '0;
    Q_IF    = '0;

    // ---------------- reset ----------------
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    check("rst i",   int'(dn_i),   0);
    check("rst q",   int'(dn_q),   0);
    check("rst rdy", int'(dn_rdy), 0);
    check_lo("rst", 1, 0);
    repeat (3) @(negedge clk);
    check("idle i",   int'(dn_i),   0);
    check("idle rdy", int'(dn_rdy), 0);
    check_lo("idle", 1, 0);

    // ---------------- constant I = 20, two full LO turns ----------------
    for (int k = 0; k < 8; k++) begin
      check_lo($sformatf("i20 lo%0d", k), exp_cos[k % 4], exp_sin[k % 4]);
      strobe($sformatf("i20 s%0d", k), 20, 0,
             exp_bi[k % 4], exp_bq[k % 4],
             exp_bi[k % 4], -exp_bq[k % 4]);
    end

    // ---------------- constant Q = 30 ----------------
    strobe("q30 s0", 0, 30,   0,  30,   0,  30);
    strobe("q30 s1", 0, 30,  30,   0, -30,   0);
    strobe("q30 s2", 0, 30,   0, -30,   0, -30);
    strobe("q30 s3", 0, 30, -30,   0,  30,   0);

    // ---------------- saturation of -64 ----------------
    strobe("sat ph0",   0,   0,   0,   0,   0,   0);
    strobe("sat ph1", -64, -64, -64,  63,  63, -64);
    strobe("sat ph2", -64, -64,  63,  63,  63,  63);
    strobe("sat ph3", -64, -64,  63, -64, -64,  63);

    // ---------------- fs/4 tone mixes down to DC ----------------
    strobe("tone n0",  40,   0, 40, 0,  40,   0);
    strobe("tone n1",   0,  40, 40, 0, -40,   0);
    strobe("tone n2", -40,   0, 40, 0,  40,   0);
    strobe("tone n3",   0, -40, 40, 0, -40,   0);

    // ---------------- back-to-back strobes, LO wraps ----------------
    @(negedge clk);
    ADC_rdy = 1'b1;
    I_IF    = 7'sd20;
    Q_IF    = '0;
    for (int k = 0; k < 4; k++) begin
      check_lo($sformatf("b2b lo%0d", k), exp_cos[k], exp_sin[k]);
      @(negedge clk);
      check($sformatf("b2b rdy%0d", k), int'(dn_rdy), 1);
      check($sformatf("b2b i%0d", k),   int'(dn_i),   exp_bi[k]);
      check($sformatf("b2b q%0d", k),   int'(dn_q),   exp_bq[k]);
    end
    check_lo("b2b wrap", 1, 0);

    // Two more edges leave the LO at PH2, then reset lands between edges
    repeat (2) @(negedge clk);
    check_lo("b2b ph2", 3, 0);
    check("b2b pre-rst i", int'(dn_i), 0);
    check("b2b pre-rst q", int'(dn_q), -20);
    #2;
    resetn = 1'b0;
    #1;
    check("mid-rst i",   int'(dn_i),   0);
    check("mid-rst q",   int'(dn_q),   0);
    check("mid-rst rdy", int'(dn_rdy), 0);
    check_lo("mid-rst", 1, 0);
    ADC_rdy = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    strobe("post-rst", 20, 0, 20, 0, 20, 0);
    check_lo("post-rst lo", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
